tx_eth_frame: RTL
=================

# tx_eth_frame

Ethernet framer stage directly downstream of the ARP/IP payload builders in the transmit path. It takes one byte-wide AXI-Stream payload per frame (first byte flagged by `tuser`, last by `tlast`) and emits a complete wire frame:
- preamble/SFD;
- destination MAC, source MAC, EtherType;
- payload, zero-padded to the 46-byte minimum;
- CRC-32 FCS;
- an enforced inter-frame gap.

## Interface
- `IFG_BYTES`, 12, idle cycles (m_axis_tvalid low) inserted after the last FCS byte
- `MIN_PAYLOAD`, 46, minimum payload length in bytes; shorter payloads are padded with 0x00
- `s_axis_aclk`  in  1  sole clock, all logic on rising edge
- `s_axis_aresetn`  in  1  asynchronous, active-low reset
- `eth_destMac`  in  48  destination MAC, byte [47:40] sent first
- `eth_srcMac`  in  48  source MAC, byte [47:40] sent first
- `eth_type`  in  16  EtherType, [15:8] sent first (0x0806 ARP, 0x0800 IPv4)
- `s_axis_tdata`  in  8  payload byte
- `s_axis_tvalid`  in  1  payload byte valid
- `s_axis_tready`  out  1  payload byte accepted when high with tvalid
- `s_axis_tuser`  in  1  start-of-payload marker, on first byte
- `s_axis_tlast`  in  1  last payload byte
- `m_axis_tdata`  out  8  frame byte
- `m_axis_tvalid`  out  1  frame byte valid
- `m_axis_tready`  in  1  downstream accept
- `m_axis_tuser`  out  1  high on first preamble byte only
- `m_axis_tlast`  out  1  high on last FCS byte only

## Operation
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG. An 8-bit byte counter (`cnt`) indexes within a state. A 16-bit payload counter (`plen`) saturates at 0xFFFF.
- IDLE:
  - `s_axis_tready`=0.
  - On `s_axis_tvalid & s_axis_tuser`, latch `eth_destMac`, `eth_srcMac` and `eth_type`, then go to PREAMBLE.
  - `tvalid` without `tuser` in IDLE is not consumed and waits; upstream must not do this.
- PREAMBLE: 7×0x55 then 0xD5. `m_axis_tuser`=1 on the first 0x55.
- HEADER: 14 bytes in order: destMac (6), srcMac (6), type (2). CRC starts at the first destMac byte.
- PAYLOAD:
  - `s_axis_tready` = (!m_axis_tvalid | m_axis_tready); each accepted byte is forwarded, CRC-updated, and increments `plen`.
  - `s_axis_tuser` inside a frame is ignored.
  - When `s_axis_tvalid` is low, `m_axis_tvalid` drops (bubbles allowed).
  - On the accepted `tlast`: if `plen` (including this byte) < MIN_PAYLOAD go to PAD, else go to FCS.
- PAD: emit 0x00, CRC-updated, until total payload+pad = MIN_PAYLOAD.
- FCS:
  - CRC-32 is reflected, poly 0xEDB88320, init 0xFFFFFFFF, final value complemented.
  - Emit the four bytes of ~crc as [7:0], [15:8], [23:16], [31:24]. `m_axis_tlast` on [31:24].
  - The CRC register is frozen during FCS.
- IFG: `m_axis_tvalid`=0 for IFG_BYTES cycles, then IDLE. A new frame's `tuser` may be presented upstream during IFG; it waits.
- Header fields changing mid-frame have no effect, since they are latched.

## Timing
- Output register: `m_axis_*` registered. It loads a new byte when (!m_axis_tvalid | m_axis_tready) and holds otherwise, with tdata/tuser/tlast stable while tvalid & !tready.
- Reset values: `m_axis_tdata`=0x00, `m_axis_tvalid`=0, `m_axis_tuser`=0, `m_axis_tlast`=0, `s_axis_tready`=0. State=IDLE, counters=0, CRC=0xFFFFFFFF.
- Latency: first preamble byte valid one cycle after the IDLE cycle that sees `tvalid&tuser`.
- Frame length: output byte count = 8+14+max(N,MIN_PAYLOAD)+4.
- Continuous cycle count, with m_axis_tready=1 and payload always valid: frame occupies exactly that many consecutive cycles, followed by IFG_BYTES idle cycles.
- Backpressure: m_axis_tready low freezes state, counters, CRC and `s_axis_tready`=0.
- Reset asserted mid-frame:
  - outputs go to reset values immediately (asynchronous);
  - the partial frame is dropped, with no tlast;
  - after release the block waits in IDLE for a fresh `tuser`.
- `plen` saturation only affects pad decision; no length limit enforced.

## Test plan
- 28-byte ARP payload, eth_type=0x0806, m_axis_tready=1 → 8+14+28 payload + 18 0x00 pad + 4 FCS = 72 valid bytes. tuser on byte 0 (0x55), byte 7 = 0xD5, bytes 20–21 = 0x08,0x06, tlast on byte 71, then 12 idle cycles. CRC over bytes 8..71 run through the same reflected CRC (no final XOR) yields residue 0xDEBB20E3.
- 46-byte payload → no pad, 72 bytes total. 60-byte payload → 86 bytes total. Both pass the residue check.
- Random m_axis_tready (50%) on a 1-byte payload → byte stream identical to the ready=1 run. Data held stable while stalled.
- Payload with s_axis_tvalid gaps of 1–3 cycles → output bubbles only, identical byte content and FCS.
- Back-to-back: second `tuser` presented during IFG → second preamble starts exactly IFG_BYTES idle cycles after first tlast.
- s_axis_aresetn pulsed low during HEADER → outputs 0 immediately. The next frame after release is complete and correct, with no residue of the aborted frame.

Source files
------------

// File: rtl/tx_eth_frame.sv
// Byte-wide Ethernet framer: wraps one AXI-Stream payload with preamble/SFD,
// MAC header, zero pad, CRC-32 FCS and a fixed inter-frame gap.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for tvalid & tuser; first 0x55 is loaded on exit
// PREAMBLE | remaining 6x 0x55 then 0xD5
// HEADER   | 14 latched header bytes (dest, src, type), CRC running
// PAYLOAD  | forward upstream bytes, CRC running, count plen
// PAD      | emit 0x00 until payload + pad reaches MIN_PAYLOAD
// FCS      | emit ~crc LSB byte first, tlast on the fourth byte
// IFG      | tvalid low for IFG_BYTES cycles (down-counter on cnt)
module tx_eth_frame #(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 46
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic [47:0] eth_destMac,
  input  logic [47:0] eth_srcMac,
  input  logic [15:0] eth_type,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  state_t            state_q, state_nxt;
  logic [7:0]        cnt_q, cnt_nxt;
  logic [15:0]       plen_q, plen_nxt, plen_inc;
  logic [31:0]       crc_q, crc_nxt;
  logic [13:0][7:0]  hdr_q, hdr_nxt;
  logic [3:0][7:0]   fcs_b;
  logic              adv;
  logic [7:0]        out_data;
  logic              out_valid, out_user, out_last;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // The output register only advances when it is empty or being drained.
  assign adv      = !m_axis_tvalid || m_axis_tready;
  assign plen_inc = (plen_q == 16'hFFFF) ? plen_q : plen_q + 16'd1;
  assign fcs_b    = ~crc_q;

  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    plen_nxt      = plen_q;
    crc_nxt       = crc_q;
    hdr_nxt       = hdr_q;
    out_data      = 8'h00;
    out_valid     = 1'b0;
    out_user      = 1'b0;
    out_last      = 1'b0;
    s_axis_tready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (adv && s_axis_tvalid && s_axis_tuser) begin
          for (int i = 0; i < 6; i++) begin
            hdr_nxt[i]     = eth_destMac[47-8*i -: 8];
            hdr_nxt[6+i]   = eth_srcMac[47-8*i -: 8];
          end
          hdr_nxt[12] = eth_type[15:8];
          hdr_nxt[13] = eth_type[7:0];
          crc_nxt     = CRC_INIT;
          plen_nxt    = 16'd0;
          cnt_nxt     = 8'd1;
          out_valid   = 1'b1;
          out_data    = 8'h55;
          out_user    = 1'b1;
          state_nxt   = S_PREAMBLE;
        end
      end

      S_PREAMBLE: begin
        if (adv) begin
          out_valid = 1'b1;
          out_data  = (cnt_q == 8'd7) ? 8'hD5 : 8'h55;
          if (cnt_q == 8'd7) begin
            cnt_nxt   = 8'd0;
            state_nxt = S_HEADER;
          end else begin
            cnt_nxt = cnt_q + 8'd1;
          end
        end
      end

      S_HEADER: begin
        if (adv) begin
          out_valid = 1'b1;
          out_data  = hdr_q[cnt_q[3:0]];
          crc_nxt   = crc_upd(crc_q, hdr_q[cnt_q[3:0]]);
          if (cnt_q == 8'd13) begin
            cnt_nxt   = 8'd0;
            state_nxt = S_PAYLOAD;
          end else begin
            cnt_nxt = cnt_q + 8'd1;
          end
        end
      end

      S_PAYLOAD: begin
        s_axis_tready = adv;
        if (adv && s_axis_tvalid) begin
          out_valid = 1'b1;
          out_data  = s_axis_tdata;
          crc_nxt   = crc_upd(crc_q, s_axis_tdata);
          plen_nxt  = plen_inc;
          if (s_axis_tlast) begin
            cnt_nxt   = 8'd0;
            state_nxt = (plen_inc < 16'(MIN_PAYLOAD)) ? S_PAD : S_FCS;
          end
        end
      end

      S_PAD: begin
        if (adv) begin
          out_valid = 1'b1;
          out_data  = 8'h00;
          crc_nxt   = crc_upd(crc_q, 8'h00);
          plen_nxt  = plen_inc;
          if (plen_inc >= 16'(MIN_PAYLOAD)) begin
            cnt_nxt   = 8'd0;
            state_nxt = S_FCS;
          end
        end
      end

      S_FCS: begin
        if (adv) begin
          out_valid = 1'b1;
          out_data  = fcs_b[cnt_q[1:0]];
          out_last  = (cnt_q == 8'd3);
          if (cnt_q == 8'd3) begin
            cnt_nxt   = 8'(IFG_BYTES - 1);
            state_nxt = (IFG_BYTES == 0) ? S_IDLE : S_IFG;
          end else begin
            cnt_nxt = cnt_q + 8'd1;
          end
        end
      end

      S_IFG: begin
        if (adv) begin
          if (cnt_q == 8'd0) state_nxt = S_IDLE;
          else               cnt_nxt   = cnt_q - 8'd1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      plen_q  <= 16'd0;
      crc_q   <= CRC_INIT;
      hdr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      plen_q  <= plen_nxt;
      crc_q   <= crc_nxt;
      hdr_q   <= hdr_nxt;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (adv) begin
      m_axis_tdata  <= out_data;
      m_axis_tvalid <= out_valid;
      m_axis_tuser  <= out_user;
      m_axis_tlast  <= out_last;
    end
  end

endmodule
